// File: rtl/if_id_buffer_pkg.sv
// if_id_buffer_pkg: shared bubble constants and fetch entry type for the IF/ID buffer
package if_id_buffer_pkg;
  localparam logic [31:0] BUBBLE_PC = 32'h0;
  localparam logic [31:0] NOP_INST = 32'h0;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/if_id_buffer_if.sv
// if_id_buffer_if: fetch request/response, pipeline control and ID register signals
interface if_id_buffer_if;
  logic [31:0] if_pc;
  logic if_req_fire;
  logic if_req_allow;
  logic inst_rvalid;
  logic [31:0] inst_rdata;
  logic if_id_stall;
  logic if_id_refresh;
  logic id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  modport master (
    output if_pc, if_req_fire, inst_rvalid, inst_rdata, if_id_stall, if_id_refresh,
    input if_req_allow, id_valid, id_pc, id_inst
  );
  modport slave (
    input if_pc, if_req_fire, inst_rvalid, inst_rdata, if_id_stall, if_id_refresh,
    output if_req_allow, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/if_id_buffer_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush, head-of-queue output and occupancy count
module sync_fifo #(
  parameter int W = 32,
  parameter int D = 2
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic flush,
  input logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(D):0] count
);
  localparam int AW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(D) + 1;
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp == AW'(D - 1) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= rp == AW'(D - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: tracks in-flight fetches, buffers responses under stall, drops wrong-path responses after refresh
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int MAX_OUT = 2,
  parameter int BUF_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  if_id_buffer_if.slave bus
);
  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int BW = $clog2(BUF_DEPTH) + 1;
  localparam fetch_entry_t BUBBLE = '{pc: BUBBLE_PC, inst: NOP_INST};
  logic [CW-1:0] ocnt, dcnt, ocnt_next;
  logic [CW-1:0] pcnt;
  logic [BW-1:0] bcnt;
  logic [31:0] pq_head;
  fetch_entry_t bf_head, live_entry, id_q, id_next;
  logic live, bf_pop, bf_push, id_valid_q, valid_next;
  always_comb begin
    live = bus.inst_rvalid && dcnt == '0;
    ocnt_next = ocnt + CW'(bus.if_req_fire) - CW'(bus.inst_rvalid);
    bf_pop = !bus.if_id_refresh && !bus.if_id_stall && bcnt != '0;
    bf_push = live && !bus.if_id_refresh && (bus.if_id_stall || bcnt != '0);
    live_entry = '{pc: pq_head, inst: bus.inst_rdata};
    id_next = bf_pop ? bf_head : live ? live_entry : BUBBLE;
    valid_next = bf_pop || live;
  end
  // every live response is guaranteed a holding slot, so bf_push never overflows
  assign bus.if_req_allow = int'(ocnt) < MAX_OUT
                         && int'(ocnt) - int'(dcnt) + int'(bcnt) < BUF_DEPTH;
  assign bus.id_valid = id_valid_q;
  assign bus.id_pc = id_q.pc;
  assign bus.id_inst = id_q.inst;
  sync_fifo #(.W(32), .D(MAX_OUT)) u_pc_queue (
    .clk(clk),
    .rst(rst),
    .push(bus.if_req_fire && !bus.if_id_refresh),
    .pop(live && !bus.if_id_refresh),
    .flush(bus.if_id_refresh),
    .din(bus.if_pc),
    .dout(pq_head),
    .count(pcnt)
  );
  sync_fifo #(.W(64), .D(BUF_DEPTH)) u_hold_fifo (
    .clk(clk),
    .rst(rst),
    .push(bf_push),
    .pop(bf_pop),
    .flush(bus.if_id_refresh),
    .din(live_entry),
    .dout(bf_head),
    .count(bcnt)
  );
  // a request fired in the refresh cycle is wrong-path, so all of ocnt_next is stale
  always_ff @(posedge clk) begin
    if (rst) begin
      ocnt <= '0;
      dcnt <= '0;
      id_valid_q <= 1'b0;
      id_q <= BUBBLE;
    end else begin
      ocnt <= ocnt_next;
      dcnt <= bus.if_id_refresh ? ocnt_next : dcnt - CW'(bus.inst_rvalid && dcnt != '0);
      if (bus.if_id_refresh) begin
        id_valid_q <= 1'b0;
        id_q <= BUBBLE;
      end else if (!bus.if_id_stall) begin
        id_valid_q <= valid_next;
        id_q <= id_next;
      end
    end
  end
  a_fire_allowed: assert property (@(posedge clk) disable iff (rst) bus.if_req_fire |-> bus.if_req_allow);
  a_pq_tracks_live: assert property (@(posedge clk) disable iff (rst) int'(pcnt) == int'(ocnt) - int'(dcnt));
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed scoreboard bench for the IF/ID fetch buffer
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic ld = 1'b0;
  fetch_entry_t sb[$];
  if_id_buffer_if bus();
  if_id_buffer #(.MAX_OUT(2), .BUF_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic f = 0, input logic [31:0] p = 0, input logic rv = 0,
                     input logic [31:0] rd = 0, input logic st = 0, input logic rf = 0);
    bus.if_req_fire = f;
    bus.if_pc = p;
    bus.inst_rvalid = rv;
    bus.inst_rdata = rd;
    bus.if_id_stall = st;
    bus.if_id_refresh = rf;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_id(input logic [31:0] pc, input logic [31:0] inst);
    sb.push_back('{pc: pc, inst: inst});
  endtask
  always @(posedge clk) ld <= rst || bus.if_id_refresh || !bus.if_id_stall;
  always @(negedge clk) begin
    if (ld) begin
      if (bus.id_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_id: got %h/%h expected no instruction", bus.id_pc, bus.id_inst);
        end else begin
          fetch_entry_t e;
          e = sb.pop_front();
          chk("id_entry", {bus.id_pc, bus.id_inst}, {e.pc, e.inst});
        end
      end else begin
        chk("bubble", {bus.id_pc, bus.id_inst}, 64'h0);
      end
    end
  end
  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_valid", 64'(bus.id_valid), 64'h0);
    chk("rst_pc_inst", {bus.id_pc, bus.id_inst}, 64'h0);
    chk("rst_allow", 64'(bus.if_req_allow), 64'h1);
    cyc(1, 32'hBFC00000);
    cyc();
    expect_id(32'hBFC00000, 32'h24080001);
    cyc(0, 0, 1, 32'h24080001);
    chk("t1_valid", 64'(bus.id_valid), 64'h1);
    cyc(1, 32'hBFC00000, 0, 0, 1);
    cyc(1, 32'hBFC00004, 0, 0, 1);
    expect_id(32'hBFC00000, 32'h24090002);
    expect_id(32'hBFC00004, 32'h240A0003);
    cyc(0, 0, 1, 32'h24090002, 1);
    cyc(0, 0, 1, 32'h240A0003, 1);
    chk("t2_bcnt", 64'(dut.bcnt), 64'h2);
    chk("t2_allow", 64'(bus.if_req_allow), 64'h0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t2_hold", {31'h0, bus.id_valid, bus.id_inst}, {31'h0, 1'b1, 32'h24080001});
    cyc();
    chk("t2_first_pc", 64'(bus.id_pc), 64'hBFC00000);
    cyc();
    chk("t2_second_pc", 64'(bus.id_pc), 64'hBFC00004);
    cyc();
    chk("t2_allow_after", 64'(bus.if_req_allow), 64'h1);
    cyc(1, 32'hBFC000A0);
    cyc(1, 32'hBFC000A4);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t3_dcnt", 64'(dut.dcnt), 64'h2);
    chk("t3_bubble", {31'h0, bus.id_valid, bus.id_pc}, 64'h0);
    cyc(0, 0, 1, 32'hDEADBEEF);
    cyc(0, 0, 1, 32'hDEADBEEF);
    chk("t3_dcnt_drained", 64'(dut.dcnt), 64'h0);
    chk("t3_allow", 64'(bus.if_req_allow), 64'h1);
    cyc(1, 32'hBFC00380);
    expect_id(32'hBFC00380, 32'h40806000);
    cyc(0, 0, 1, 32'h40806000);
    chk("t3_new_pc", 64'(bus.id_pc), 64'hBFC00380);
    cyc(0, 0, 0, 0, 1, 1);
    chk("t4_refresh_wins", {31'h0, bus.id_valid, bus.id_pc}, 64'h0);
    cyc(1, 32'hBFC00010);
    cyc(1, 32'hBFC00014, 1, 32'h11111111, 0, 1);
    chk("t5_dcnt", 64'(dut.dcnt), 64'h1);
    chk("t5_ocnt", 64'(dut.ocnt), 64'h1);
    chk("t5_valid", 64'(bus.id_valid), 64'h0);
    cyc(0, 0, 1, 32'h22222222);
    chk("t5_counts_clear", {32'(dut.ocnt), 32'(dut.dcnt)}, 64'h0);
    cyc(1, 32'hBFC00020, 0, 0, 1);
    cyc(1, 32'hBFC00024, 0, 0, 1);
    cyc(0, 0, 1, 32'h33333333, 1);
    cyc(0, 0, 1, 32'h44444444, 1);
    chk("t6_bcnt_full", 64'(dut.bcnt), 64'h2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_id", {31'h0, bus.id_valid, bus.id_pc}, 64'h0);
    chk("t6_inst", 64'(bus.id_inst), 64'h0);
    chk("t6_allow", 64'(bus.if_req_allow), 64'h1);
    chk("t6_bcnt", 64'(dut.bcnt), 64'h0);
    cyc();
    cyc();
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Fetch-side consumer of the pipeline control unit's `if_id_stall` / `if_id_refresh`.
- Tracks in-flight instruction fetches and buffers returned instructions while ID is stalled.
- Discards wrong-path responses after a refresh.
- Drives the IF/ID pipeline register; a bubble is presented as `id_pc == 0`, which the control unit decodes as an empty ID stage.

Parameters:
- MAX_OUT, 2, maximum accepted-but-unanswered fetch requests (power of 2, ≥1).
- BUF_DEPTH, 2, instruction holding FIFO entries (power of 2, ≥1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_pc  in  32  PC of the fetch request presented this cycle.
- if_req_fire  in  1  fetch request accepted by the memory side this cycle (req && addr_ok).
- if_req_allow  out  1  fetch unit may issue a request this cycle (combinational).
- inst_rvalid  in  1  instruction response returned this cycle (in request order).
- inst_rdata  in  32  response instruction word.
- if_id_stall  in  1  hold the ID register.
- if_id_refresh  in  1  flush the wrong path.
- id_valid  out  1  ID register holds a real instruction.
- id_pc  out  32  ID instruction PC; 0 when bubble.
- id_inst  out  32  ID instruction word; 0 when bubble.

Behaviour:
- Reset (rst=1 at edge):
  - PC queue, holding FIFO, ocnt, dcnt all cleared.
  - id_valid=0, id_pc=0, id_inst=0.
  - if_req_allow=1 while counts are zero.
- PC queue (depth MAX_OUT):
  - if_req_fire pushes if_pc.
  - A non-discarded inst_rvalid pops the oldest PC, pairing it with inst_rdata.
- ocnt = outstanding requests, including stale ones.
  - +1 on fire, -1 on any rvalid.
  - Both in the same cycle: unchanged.
- dcnt = stale responses still to arrive.
  - While dcnt>0, inst_rvalid is dropped (no FIFO write, no PC pop) and dcnt decrements.
- if_req_allow = (ocnt < MAX_OUT) && (ocnt - dcnt + bcnt < BUF_DEPTH), with bcnt = FIFO occupancy.
  - Every live response is therefore guaranteed a FIFO slot.
  - if_req_fire while allow=0 is a protocol violation; assert in simulation.
- ID register update, when no refresh and no stall:
  - If the FIFO is non-empty: load its head {pc, inst} and pop it; id_valid=1.
  - Else, if a live response arrives this cycle: bypass it directly (response at cycle t visible at ID at t+1).
  - Else: bubble (id_valid=0, id_pc=0, id_inst=0).
  - A live response not consumed by the bypass is written to the FIFO.
- Stall (if_id_stall=1, no refresh):
  - ID register holds.
  - Live responses are written into the FIFO; nothing pops.
- Refresh (if_id_refresh=1) has priority over stall:
  - ID register set to bubble next cycle.
  - FIFO and PC queue cleared.
  - dcnt <= ocnt_next − (live response this cycle ? 0 : 0), i.e. every request outstanding after this edge is stale.
  - This includes a request firing in the refresh cycle itself (that request is wrong-path; the fetch unit redirects the cycle after).
- Same-cycle combinations:
  - Response and fire together: both processed.
  - Response during refresh: dropped.
- Width rules:
  - ocnt and dcnt are $clog2(MAX_OUT)+1 bits.
  - bcnt is $clog2(BUF_DEPTH)+1 bits.
  - FIFO pointers wrap modulo BUF_DEPTH.
- Reset mid-operation overrides everything:
  - Outstanding responses after reset are not discarded.
  - The memory side is reset together with this block.

Decomposition:
- Shared package constants: `BUBBLE_PC = 32'h0`, `NOP_INST = 32'h0`.
- Shared package typedef: `fetch_entry_t` {pc[31:0], inst[31:0]}.
- One natural sub-module, `sync_fifo` (parameterised width/depth, push/pop/flush, count), instantiated twice:
  - PC queue (width 32).
  - Holding FIFO (width 64).

Test Plan:
1. Fire pc 0xBFC00000, response 0x24080001 two cycles later, no stall → id_valid=1, id_pc=0xBFC00000, id_inst=0x24080001 the cycle after the response.
2. Two fires (0xBFC00000, 0xBFC00004), stall held 4 cycles during both responses → ID holds its prior value; bcnt=2, if_req_allow=0; on stall release ID shows 0xBFC00000 then 0xBFC00004 on consecutive cycles.
3. Two outstanding requests, refresh asserted → next cycle id_pc=0 and id_valid=0, dcnt=2; next two responses (e.g. 0xDEADBEEF) never reach ID; a new fire at 0xBFC00380 answered with 0x40806000 appears at ID.
4. Refresh and stall together with a valid ID → refresh wins: ID becomes bubble.
5. Refresh in the same cycle as a fire and as a response → response dropped, fired request counted stale (dcnt=1), ocnt consistent.
6. rst pulsed while FIFO holds 2 entries → next cycle id_valid=0, id_pc=0, id_inst=0, if_req_allow=1, bcnt=0.
